// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
// Holds the FSM state encoding so the top and any monitors agree on it.
package mem_arb_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer register flips to the loser on grant.
// Zero latency; grants only while i_en is high, otherwise requests simply wait.
module rr_arb2 (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1
);

   logic r_prio1;   // 1: port 1 wins a tie
   logic w_gnt0;
   logic w_gnt1;

   always_comb begin
      w_gnt0 = i_en & i_req0 & (~i_req1 | ~r_prio1);
      w_gnt1 = i_en & i_req1 & (~i_req0 |  r_prio1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prio1 <= 1'b0;
      end else if (w_gnt0) begin
         r_prio1 <= 1'b1;
      end else if (w_gnt1) begin
         r_prio1 <= 1'b0;
      end
   end

   assign o_gnt0 = w_gnt0;
   assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin grant, one-shot mem command, ack wait with timeout.
// Latency req->done is 3 cycles minimum; the losing port holds req and waits in IDLE.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_done0,
   output logic              o_done1,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_err,
   output logic              o_busy,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   state_t            r_state;
   logic              r_owner;
   logic [7:0]        r_cnt;
   logic              r_done0;
   logic              r_done1;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic              r_busy;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic       w_gnt0;
   logic       w_gnt1;
   logic [7:0] w_cnt_nxt;

   rr_arb2 u_rr_arb2 (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (r_state == ST_IDLE),
      .i_req0  (i_req0),
      .i_req1  (i_req1),
      .o_gnt0  (w_gnt0),
      .o_gnt1  (w_gnt1)
   );

   assign w_cnt_nxt = r_cnt + 8'd1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt0 | w_gnt1) begin
                  r_owner     <= w_gnt1;
                  r_mem_we    <= w_gnt1 ? i_we1    : i_we0;
                  r_mem_addr  <= w_gnt1 ? i_addr1  : i_addr0;
                  r_mem_wdata <= w_gnt1 ? i_wdata1 : i_wdata0;
                  r_mem_en    <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A late ack on the final counted cycle still beats the timeout.
               if (i_mem_ack) begin
                  r_rdata <= r_mem_we ? '0 : i_mem_rdata;
                  r_err   <= 1'b0;
                  r_done0 <= ~r_owner;
                  r_done1 <= r_owner;
                  r_state <= ST_DONE;
               end else if (w_cnt_nxt == TO_CNT) begin
                  r_cnt   <= w_cnt_nxt;
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_done0 <= ~r_owner;
                  r_done1 <= r_owner;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_done0     = r_done0;
   assign o_done1     = r_done1;
   assign o_rdata     = r_rdata;
   assign o_err       = r_err;
   assign o_busy      = r_busy;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: commands, responses and completions are queued at stimulus time.
// A memory responder pops per-command ack timing; a monitor compares every mem_en and done pulse.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 255;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] rdata;
      logic          err;
   } cpl_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [7:0]    dly;
      logic          noack;
   } rsp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          done0, done1, err, busy, mem_en, mem_we;
   logic [DW-1:0] rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          ack_resp = 1'b0;
   logic          ack_spur = 1'b0;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata = '0;

   assign mem_ack = ack_resp | ack_spur;

   cmd_t cmd_q[$];
   cpl_t cpl_q[$];
   rsp_t rsp_q[$];
   cmd_t last_cmd = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int en_cyc = 0, done_cyc = 0;
   int n_en = 0, n_done = 0, n_done1 = 0;
   logic prev_en = 1'b0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req0      (req0),
      .i_req1      (req1),
      .i_we0       (we0),
      .i_we1       (we1),
      .i_addr0     (addr0),
      .i_addr1     (addr1),
      .i_wdata0    (wdata0),
      .i_wdata1    (wdata1),
      .o_done0     (done0),
      .o_done1     (done1),
      .o_rdata     (rdata),
      .o_err       (err),
      .o_busy      (busy),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_ack   (mem_ack),
      .i_mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: compare each command strobe and each completion against the queues.
   always @(negedge clk) begin
      if (mem_en) begin
         en_cyc = cyc;
         n_en++;
         check("mem_en_single_cycle", prev_en, 1'b0);
         check("cmd_expected", cmd_q.size() > 0, 1'b1);
         if (cmd_q.size() > 0) begin
            last_cmd = cmd_q.pop_front();
            check("cmd_we", mem_we, last_cmd.we);
            check("cmd_addr", mem_addr, last_cmd.addr);
            check("cmd_wdata", mem_wdata, last_cmd.wdata);
         end
      end
      prev_en = mem_en;
      if (done0 | done1) begin
         cpl_t c;
         done_cyc = cyc;
         n_done++;
         if (done1) n_done1++;
         check("done_one_hot", done0 & done1, 1'b0);
         check("done_expected", cpl_q.size() > 0, 1'b1);
         if (cpl_q.size() > 0) begin
            c = cpl_q.pop_front();
            check("done_port", done1, c.port);
            check("done_rdata", rdata, c.rdata);
            check("done_err", err, c.err);
            check("done_busy", busy, 1'b1);
            check("hold_addr", mem_addr, last_cmd.addr);
            check("hold_we", mem_we, last_cmd.we);
            check("hold_wdata", mem_wdata, last_cmd.wdata);
         end
      end
   end

   // Memory model: ack timing per command comes from rsp_q (dly=1 acks in the cycle after mem_en).
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (mem_en && rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            if (!r.noack) begin
               repeat (int'(r.dly)) @(posedge clk);
               #1 ack_resp = 1'b1;
               mem_rdata = r.data;
               @(posedge clk);
               #1 ack_resp = 1'b0;
               mem_rdata = 32'h0BAD_0BAD;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int max);
      int start = n_done;
      int k = 0;
      while (n_done == start && k < max) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, n_done > start, 1'b1);
   endtask

   task automatic wait_en(input string tag, input int max);
      int start = n_en;
      int k = 0;
      while (n_en == start && k < max) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, n_en > start, 1'b1);
   endtask

   task automatic push_txn(input logic port, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] md,
                           input int dly, input logic noack, input logic exp_done);
      cmd_q.push_back('{we: we, addr: a, wdata: wd});
      rsp_q.push_back('{data: md, dly: 8'(dly), noack: noack});
      if (exp_done)
         cpl_q.push_back('{port: port, rdata: (we || noack) ? '0 : md, err: noack});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      int t0;
      int saved;
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int saved;

      // Reset state
      tick(3);
      @(negedge clk);
      check("rst_ctrl", {done0, done1, busy, mem_en, err, mem_we}, 6'b0);
      check("rst_rdata", rdata, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      tick(1);
      reset = 1'b0;

      // Scenario 1: single read, fastest ack
      tick(1);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
      t0 = cyc;
      push_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b1);
      wait_done("s1_done_seen", 20);
      check("s1_en_latency", en_cyc - t0, 1);
      check("s1_done_latency", done_cyc - t0, 3);
      tick(1);
      req0 = 1'b0;
      check("s1_no_done1", n_done1, 0);

      // Scenario 2: simultaneous requests, pointer after reset favours port 0
      do_reset();
      req0 = 1'b1; addr0 = 32'h300;
      req1 = 1'b1; addr1 = 32'h400; we1 = 1'b0;
      push_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'hA0A0_0001, 1, 1'b0, 1'b1);
      wait_done("s2a_done_seen", 20);
      tick(1);
      req0 = 1'b0; req1 = 1'b0;
      tick(3);
      check("s2a_port1_not_served", n_done1, 0);
      // Same experiment again: port 0 won last time, so port 1 goes first
      req0 = 1'b1; addr0 = 32'h310;
      req1 = 1'b1; addr1 = 32'h410;
      push_txn(1'b1, 1'b0, 32'h410, 32'h0, 32'hB0B0_0002, 2, 1'b0, 1'b1);
      push_txn(1'b0, 1'b0, 32'h310, 32'h0, 32'hC0C0_0003, 1, 1'b0, 1'b1);
      wait_done("s2b_first_done", 20);
      check("s2b_port1_first", n_done1, 1);
      tick(1);
      req1 = 1'b0;
      wait_done("s2b_second_done", 20);
      tick(1);
      req0 = 1'b0;

      // Scenario 3: port 1 write returns rdata 0 despite garbage on mem_rdata
      tick(2);
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h12345678;
      push_txn(1'b1, 1'b1, 32'h200, 32'h12345678, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);
      wait_done("s3_done_seen", 20);
      tick(1);
      req1 = 1'b0; we1 = 1'b0;

      // Scenario 4: no ack, timeout completion
      tick(2);
      req0 = 1'b1; addr0 = 32'h500;
      push_txn(1'b0, 1'b0, 32'h500, 32'h0, 32'h1111_2222, 1, 1'b1, 1'b1);
      wait_done("s4_done_seen", TO + 30);
      check("s4_timeout_latency", done_cyc - en_cyc, TO + 1);
      tick(1);
      req0 = 1'b0;

      // Scenario 5: reset in WAIT, ack arrives after reset and is ignored
      tick(2);
      req0 = 1'b1; addr0 = 32'h600;
      push_txn(1'b0, 1'b0, 32'h600, 32'h0, 32'h5555_5555, 6, 1'b0, 1'b0);
      wait_en("s5_en_seen", 10);
      saved = n_done;
      tick(3);
      reset = 1'b1; req0 = 1'b0;
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      check("s5_busy_after_reset", busy, 1'b0);
      tick(10);
      check("s5_no_done", n_done, saved);
      check("s5_idle", {busy, done0, done1}, 3'b0);
      req0 = 1'b1; addr0 = 32'h640;
      t0 = cyc;
      push_txn(1'b0, 1'b0, 32'h640, 32'h0, 32'h6666_7777, 1, 1'b0, 1'b1);
      wait_done("s5_next_done", 20);
      check("s5_next_latency", done_cyc - t0, 3);
      tick(1);
      req0 = 1'b0;

      // Scenario 6: spurious ack in IDLE, then req dropped during WAIT
      tick(2);
      saved = n_en;
      ack_spur = 1'b1;
      tick(1);
      ack_spur = 1'b0;
      tick(2);
      @(negedge clk);
      check("s6_idle_busy", busy, 1'b0);
      check("s6_idle_no_en", n_en, saved);
      tick(1);
      req0 = 1'b1; addr0 = 32'h700;
      push_txn(1'b0, 1'b0, 32'h700, 32'h0, 32'hCAFE_F00D, 5, 1'b0, 1'b1);
      wait_en("s6_en_seen", 10);
      tick(2);
      req0 = 1'b0;
      wait_done("s6_done_seen", 20);
      tick(3);
      check("s6_single_issue", n_en, saved + 1);

      check("queues_drained", cmd_q.size() + cpl_q.size() + rsp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Params SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 255, max cycles waiting for mem_ack.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  request; port 0 = instruction fetch, port 1 = data cache refill/writeback.
REQ-005 we0 / we1  input  1  1 = write, 0 = read.
REQ-006 addr0 / addr1  input  ADDR_W  byte address; word-aligned.
REQ-007 wdata0 / wdata1  input  DATA_W  store data.
REQ-008 done0 / done1  output  1  one-cycle completion pulse to the owning port.
REQ-009 rdata  output  DATA_W  read data; valid only in a done cycle.
REQ-010 err  output  1  timeout flag; valid only in a done cycle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mem_en  output  1  one-cycle memory command strobe.
REQ-013 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  latched command fields.
REQ-014 mem_ack  input  1  memory completion strobe.
REQ-015 mem_rdata  input  DATA_W  memory read data; valid with mem_ack.

Function
REQ-016 FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if any reqN is high, select the owner, latch we/addr/wdata of the owner, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a single request wins outright; on simultaneous requests, the port not granted most recently wins; the priority pointer updates only on grant.
REQ-019 ISSUE: assert mem_en for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-020 WAIT: on mem_ack, capture mem_rdata (reads) or 0 (writes), set err=0, and go to DONE.
REQ-021 WAIT: the 8-bit timeout counter increments each cycle; at count==TIMEOUT without mem_ack, set rdata=0 and err=1, then go to DONE.
REQ-022 DONE: pulse done of the owner for one cycle and go to IDLE.
REQ-023 Minimum latency SHALL be: req at cycle t, mem_en at t+1, earliest mem_ack at t+2, done at t+3.
REQ-024 mem_addr, mem_we and mem_wdata SHALL hold the latched values from ISSUE through DONE.
REQ-025 mem_ack in IDLE, ISSUE or DONE SHALL be ignored.
REQ-026 reqN deasserted mid-transaction SHALL be ignored; the transaction completes and done still pulses.
REQ-027 Requesters SHALL drop req in the cycle after done; a req still high in IDLE is treated as a new request.
REQ-028 No new grant SHALL occur while busy; the other port's request waits in IDLE arbitration.

Reset
REQ-029 When reset is high at a clock edge, the next state SHALL be: state=IDLE; priority pointer favours port 0; mem_en, done0, done1, err, busy = 0; rdata, mem_addr, mem_wdata, mem_we = 0; timeout counter = 0.
REQ-030 Reset mid-transaction SHALL abort silently, with no done pulse; a mem_ack arriving later SHALL be ignored.

Structure
REQ-031 The shared package mem_arb_pkg SHALL hold the state enum, the ADDR_W/DATA_W defaults and the TIMEOUT default.
REQ-032 Arbitration SHALL be a sub-module rr_arb2 (2-way round-robin arbiter with pointer register); the FSM and datapath latches live in mem_arbiter.

Verification
REQ-033 Scenario 1: req0 read, addr0=0x100, mem_ack at t+2 with mem_rdata=0xDEADBEEF -> done0 at t+3, rdata=0xDEADBEEF, err=0, done1 never asserted.
REQ-034 Scenario 2: req0 and req1 raised together after reset -> port 0 served first, then port 1; repeating the experiment serves port 1 first.
REQ-035 Scenario 3: req1 write, addr1=0x200, wdata1=0x12345678 -> mem_en for one cycle with mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; done1 gives rdata=0.
REQ-036 Scenario 4: mem_ack never arrives -> done pulse TIMEOUT+1 cycles after mem_en, err=1, rdata=0.
REQ-037 Scenario 5: reset asserted during WAIT, then mem_ack -> no done pulse, busy=0, next req0 granted normally.
REQ-038 Scenario 6: spurious mem_ack in IDLE, and req0 dropped during WAIT -> no state change in IDLE; done0 still pulses for the dropped request.
